cacheflushfsm: RTL and testbench

Sequencer that walks every set and way of a cache during a flush. It writes back each valid dirty line through a request/acknowledge handshake, then clears that line's dirty bit. It optionally invalidates the whole cache at the end. It sits beside the cache arrays and replacement logic and drives the flush address into the cache address mux while the normal cache FSM is held off.

---
 rtl/cacheflushfsm.sv | 132 +++++++++++++
 tb/tb_cacheflushfsm.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cacheflushfsm.sv
// Cache flush sequencer: walks every set/way and writes back valid dirty lines.
// It clears each dirty bit after its writeback and can invalidate the whole cache at the end.
module cacheflushfsm #(
  parameter int NUMWAYS  = 4,
  parameter int NUMLINES = 128,
  parameter int SETLEN   = $clog2(NUMLINES)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               FlushCache,
  input  logic               FlushInvalidate,
  input  logic [NUMWAYS-1:0] DirtyWay,
  input  logic [NUMWAYS-1:0] ValidWay,
  input  logic               WBAck,
  output logic [SETLEN-1:0]  FlushAdr,
  output logic [NUMWAYS-1:0] FlushWay,
  output logic               WBReq,
  output logic               ClearDirty,
  output logic               InvalidateCache,
  output logic               CacheBusy,
  output logic               FlushDone
);

  localparam int WAYLEN = $clog2(NUMWAYS);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CHECK,
    WRITEBACK,
    CLEAR,
    DONE
  } state_t;

  state_t              state_reg, state_next;
  logic [SETLEN-1:0]   set_reg, set_next;
  logic [WAYLEN-1:0]   way_reg, way_next;
  logic [NUMWAYS-1:0]  snap_reg, snap_next;
  logic                inv_reg, inv_next;
  logic                advance;
  logic                last_way, last_set;
  logic [NUMWAYS-1:0]  way_onehot;

  genvar gi;
  generate
    for (gi = 0; gi < NUMWAYS; gi++) begin : g_onehot
      assign way_onehot[gi] = (way_reg == WAYLEN'(gi));
    end
  endgenerate

  assign last_way = (way_reg == WAYLEN'(NUMWAYS - 1));
  assign last_set = (set_reg == SETLEN'(NUMLINES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      set_reg   <= '0;
      way_reg   <= '0;
      snap_reg  <= '0;
      inv_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      set_reg   <= set_next;
      way_reg   <= way_next;
      snap_reg  <= snap_next;
      inv_reg   <= inv_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    set_next   = set_reg;
    way_next   = way_reg;
    snap_next  = snap_reg;
    inv_next   = inv_reg;
    advance    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (FlushCache) begin
          state_next = READ;
          set_next   = '0;
          way_next   = '0;
          inv_next   = FlushInvalidate;
        end
      end
      READ: begin
        // Snapshot is taken once per set; ClearDirty later does not touch it.
        snap_next  = DirtyWay & ValidWay;
        state_next = CHECK;
      end
      CHECK: begin
        if (snap_reg[way_reg]) state_next = WRITEBACK;
        else                   advance    = 1'b1;
      end
      WRITEBACK: begin
        if (WBAck) state_next = CLEAR;
      end
      CLEAR: advance = 1'b1;
      DONE: begin
        // Park the address at set 0 so FlushAdr reads 0 while idle.
        state_next = IDLE;
        set_next   = '0;
        way_next   = '0;
      end
      default: state_next = IDLE;
    endcase

    if (advance) begin
      if (!last_way) begin
        way_next   = way_reg + WAYLEN'(1);
        state_next = CHECK;
      end else if (!last_set) begin
        set_next   = set_reg + SETLEN'(1);
        way_next   = '0;
        state_next = READ;
      end else begin
        state_next = DONE;
      end
    end
  end

  assign FlushAdr        = set_reg;
  assign FlushWay        = (state_reg == CHECK || state_reg == WRITEBACK || state_reg == CLEAR)
                           ? way_onehot : '0;
  assign WBReq           = (state_reg == WRITEBACK);
  assign ClearDirty      = (state_reg == CLEAR);
  assign FlushDone       = (state_reg == DONE);
  assign InvalidateCache = (state_reg == DONE) && inv_reg;
  assign CacheBusy       = (state_reg != IDLE);

endmodule

// File: tb/tb_cacheflushfsm.sv
// Directed bench for cacheflushfsm: bench-side tag memory, programmable ack latency,
// per-flush statistics compared against hand-computed cycle numbers.
module tb_cacheflushfsm;

  logic       clk = 1'b0;
  logic       reset;
  logic       FlushCache;
  logic       FlushInvalidate;
  logic [3:0] DirtyWay;
  logic [3:0] ValidWay;
  logic       WBAck;
  logic [6:0] FlushAdr;
  logic [3:0] FlushWay;
  logic       WBReq;
  logic       ClearDirty;
  logic       InvalidateCache;
  logic       CacheBusy;
  logic       FlushDone;

  cacheflushfsm #(.NUMWAYS(4), .NUMLINES(128)) dut (
    .clk             (clk),
    .reset           (reset),
    .FlushCache      (FlushCache),
    .FlushInvalidate (FlushInvalidate),
    .DirtyWay        (DirtyWay),
    .ValidWay        (ValidWay),
    .WBAck           (WBAck),
    .FlushAdr        (FlushAdr),
    .FlushWay        (FlushWay),
    .WBReq           (WBReq),
    .ClearDirty      (ClearDirty),
    .InvalidateCache (InvalidateCache),
    .CacheBusy       (CacheBusy),
    .FlushDone       (FlushDone)
  );

  always #5 clk = ~clk;

  logic [3:0] dirty_mem [0:127];
  logic [3:0] valid_mem [0:127];
  assign DirtyWay = dirty_mem[FlushAdr];
  assign ValidWay = valid_mem[FlushAdr];

  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Bus model: ack on the ack_lat-th WBReq cycle (0 = never), or tied high.
  int ack_lat = 1;
  bit ack_tied = 1'b0;
  int wb_run = 0;
  always @(negedge clk) begin
    if (WBReq) wb_run = wb_run + 1;
    else       wb_run = 0;
    WBAck = ack_tied || (WBReq && ack_lat != 0 && wb_run >= ack_lat);
  end

  // Per-flush statistics
  int done_cyc, done_cnt, busy_cnt, busy_first, wb_cnt, wb_first, wb_adr, wb_way;
  int cd_cnt, cd_adr, cd_way, inv_cnt, inv_cyc;
  int idle_adr, idle_busy, idle_way;
  bit done_seen;

  task automatic clear_mem();
    for (int i = 0; i < 128; i++) begin
      dirty_mem[i] = 4'b0000;
      valid_mem[i] = 4'b1111;
    end
  endtask

  // Cycle 0 is the cycle FlushCache is high; stats run until one cycle past FlushDone.
  task automatic run_flush(input bit inv, input int repulse);
    done_cyc = 0; done_cnt = 0; busy_cnt = 0; busy_first = 0;
    wb_cnt = 0; wb_first = 0; wb_adr = -1; wb_way = -1;
    cd_cnt = 0; cd_adr = -1; cd_way = -1; inv_cnt = 0; inv_cyc = 0;
    idle_adr = -1; idle_busy = -1; idle_way = -1; done_seen = 1'b0;
    @(negedge clk);
    FlushCache = 1'b1;
    FlushInvalidate = inv;
    @(posedge clk);
    for (int cyc = 1; cyc <= 2000; cyc++) begin
      @(negedge clk);
      FlushCache = (cyc == repulse);
      FlushInvalidate = 1'b0;
      if (done_seen && cyc == done_cyc + 1) begin
        idle_adr  = int'(FlushAdr);
        idle_busy = int'(CacheBusy);
        idle_way  = int'(FlushWay);
        break;
      end
      if (CacheBusy) begin
        busy_cnt++;
        if (busy_first == 0) busy_first = cyc;
      end
      if (WBReq) begin
        wb_cnt++;
        if (wb_first == 0) wb_first = cyc;
        wb_adr = int'(FlushAdr);
        wb_way = int'(FlushWay);
      end
      if (ClearDirty) begin
        cd_cnt++;
        cd_adr = int'(FlushAdr);
        cd_way = int'(FlushWay);
      end
      if (FlushDone) begin
        done_cnt++;
        if (!done_seen) done_cyc = cyc;
        done_seen = 1'b1;
      end
      if (InvalidateCache) begin
        inv_cnt++;
        inv_cyc = cyc;
      end
    end
    FlushCache = 1'b0;
    if (!done_seen) check_eq("flush_timeout", 0, 1);
  endtask

  initial begin
    reset = 1'b1;
    FlushCache = 1'b0;
    FlushInvalidate = 1'b0;
    WBAck = 1'b0;
    clear_mem();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_outputs", int'({FlushAdr, FlushWay, WBReq, ClearDirty,
                                     InvalidateCache, CacheBusy, FlushDone}), 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // Clean cache
    run_flush(1'b0, 0);
    check_eq("clean_done_cyc", done_cyc, 641);
    check_eq("clean_done_cnt", done_cnt, 1);
    check_eq("clean_busy_cnt", busy_cnt, 641);
    check_eq("clean_busy_first", busy_first, 1);
    check_eq("clean_wbreq", wb_cnt, 0);
    check_eq("clean_inval", inv_cnt, 0);
    check_eq("clean_idle_busy", idle_busy, 0);

    // Single dirty line: set 5, way 2, ack on the third WBReq cycle
    clear_mem();
    dirty_mem[5] = 4'b0100;
    ack_lat = 3;
    run_flush(1'b0, 0);
    check_eq("single_wb_cycles", wb_cnt, 3);
    check_eq("single_wb_first", wb_first, 30);
    check_eq("single_wb_adr", wb_adr, 5);
    check_eq("single_wb_way", wb_way, 4);
    check_eq("single_clear_cnt", cd_cnt, 1);
    check_eq("single_clear_adr", cd_adr, 5);
    check_eq("single_clear_way", cd_way, 4);
    check_eq("single_done_cyc", done_cyc, 645);

    // Dirty but invalid: no writeback
    clear_mem();
    dirty_mem[9] = 4'b0010;
    valid_mem[9] = 4'b1101;
    run_flush(1'b0, 0);
    check_eq("invalid_wb_cycles", wb_cnt, 0);
    check_eq("invalid_done_cyc", done_cyc, 641);

    // Ack tied high, last set, ways 0 and 3
    clear_mem();
    dirty_mem[127] = 4'b1001;
    ack_tied = 1'b1;
    run_flush(1'b0, 0);
    check_eq("last_wb_cycles", wb_cnt, 2);
    check_eq("last_clear_cnt", cd_cnt, 2);
    check_eq("last_wb_adr", wb_adr, 127);
    check_eq("last_wb_way", wb_way, 8);
    check_eq("last_done_cyc", done_cyc, 645);
    check_eq("last_idle_adr", idle_adr, 0);
    check_eq("last_idle_way", idle_way, 0);
    ack_tied = 1'b0;

    // Reset in the middle of a writeback that is never acknowledged
    clear_mem();
    dirty_mem[0] = 4'b0001;
    ack_lat = 0;
    @(negedge clk);
    FlushCache = 1'b1;
    @(posedge clk);
    @(negedge clk);
    FlushCache = 1'b0;
    for (int i = 0; i < 20 && !WBReq; i++) @(negedge clk);
    check_eq("rst_wbreq_seen", int'(WBReq), 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_mid_outputs", int'({FlushAdr, FlushWay, WBReq, ClearDirty,
                                       InvalidateCache, CacheBusy, FlushDone}), 0);
    reset = 1'b0;
    ack_lat = 2;
    run_flush(1'b0, 0);
    check_eq("restart_wb_first", wb_first, 3);
    check_eq("restart_wb_adr", wb_adr, 0);
    check_eq("restart_wb_way", wb_way, 1);
    check_eq("restart_done_cyc", done_cyc, 644);

    // Start re-pulsed mid-flush is ignored; invalidate requested at start
    clear_mem();
    ack_lat = 1;
    run_flush(1'b1, 100);
    check_eq("inv_done_cnt", done_cnt, 1);
    check_eq("inv_done_cyc", done_cyc, 641);
    check_eq("inv_pulse_cnt", inv_cnt, 1);
    check_eq("inv_pulse_cyc", inv_cyc, 641);
    check_eq("inv_idle_busy", idle_busy, 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
